div5_serial_64: RTL and testbench
=================================

DIV5_SERIAL_64 -- requirements
Module: div5_serial_64

Interface
REQ-001 Parameter: W, 64, dividend/quotient width; SHALL be fixed at 64 in this release.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  dividend offered.
REQ-005 Port: in_ready  output  1  block accepts a dividend.
REQ-006 Port: in_x  input  64  unsigned dividend.
REQ-007 Port: out_valid  output  1  result available.
REQ-008 Port: out_ready  input  1  consumer accepts result.
REQ-009 Port: out_q  output  64  quotient floor(in_x/5).
REQ-010 Port: out_r  output  3  remainder in_x mod 5, range 0..4.
REQ-011 Port: out_err  output  1  self-check failure flag (see Configuration).

Function
REQ-012 FSM states SHALL be IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 IDLE->BUSY on in_valid&&in_ready; the operand SHALL be latched into a 66-bit shift register, zero-extended by 2 MSBs; step counter loaded to 0; remainder register cleared to 0.
REQ-014 BUSY: one radix-8 digit per cycle, MSB-first, 22 steps; step k consumes bits [65-3k : 63-3k] of the padded operand.
REQ-015 Per step: v = 8*rem + digit (0..39); quotient digit = floor(v/5) (0..7); rem_next = v mod 5; quotient digit shifted into the quotient register LSB side.
REQ-016 The remainder register SHALL never hold a value above 4; quotient digit of step 0 SHALL be 0.
REQ-017 BUSY->DONE after step 21 completes; result visible 22 cycles after the accepting edge.
REQ-018 out_q SHALL be the low 64 bits of the 66-bit quotient register (top 2 bits always 0); out_r = final remainder.
REQ-019 DONE->IDLE on out_ready; out_q/out_r SHALL hold stable while out_valid&&!out_ready.
REQ-020 in_valid during BUSY/DONE SHALL be ignored (no handshake); one IDLE bubble between results is required.
REQ-021 out_q, out_r, out_err SHALL be 0 whenever state!=DONE.

Reset
REQ-022 rst SHALL force state IDLE, counter 0, remainder 0, quotient 0, all outputs 0 except in_ready=1 on the following cycle.
REQ-023 rst asserted mid-BUSY or in DONE SHALL abandon the operation with no out_valid pulse.
REQ-024 rst has priority over any simultaneous handshake.

Configuration
REQ-025 Macro DIV5_SELFCHECK_EN, when defined: in DONE, out_err = ((5*out_q + out_r) != latched in_x) || out_r>4, requiring a retained copy of in_x.
REQ-026 Without DIV5_SELFCHECK_EN: out_err tied 0, no operand copy, no multiplier logic synthesised; port list unchanged.

Structure
REQ-027 Shared package div5_pkg SHALL hold: DIVISOR=5, RADIX_BITS=3, N_STEPS=22, PAD_W=66, state enum type.
REQ-028 One combinational sub-module div5_digit (inputs rem[2:0], digit[2:0]; outputs qd[2:0], rn[2:0]) SHALL implement REQ-015, one instance, LUT6-mappable per output bit; behaviour for rem>4 is don't-care.
REQ-029 Datapath registers: operand shift reg, quotient shift reg, 3-bit remainder, 5-bit step counter.

Verification
REQ-030 in_x=0 -> after 22 cycles out_q=0, out_r=0, out_err=0.
REQ-031 in_x=64'hFFFF_FFFF_FFFF_FFFF -> out_q=64'h3333_3333_3333_3333, out_r=0.
REQ-032 in_x=64'h8000_0000_0000_0000 -> out_q=64'h1999_9999_9999_9999, out_r=3; in_x=7 -> out_q=1, out_r=2.
REQ-033 Backpressure: out_ready low 10 cycles in DONE -> outputs stable, in_ready low, second in_valid ignored until IDLE.
REQ-034 rst pulsed at step 10 -> no out_valid, next operand 64'd24 returns q=4, r=4 after full latency.
REQ-035 Random 10^5 operands vs. reference model, built with and without DIV5_SELFCHECK_EN; out_err never 1.

Source files
------------

// File: rtl/div5_pkg.sv
// Shared constants and state type for the serial radix-8 divide-by-5 unit.
package div5_pkg;

    localparam int unsigned DIVISOR    = 5;
    localparam int unsigned RADIX_BITS = 3;
    localparam int unsigned N_STEPS    = 22;
    localparam int unsigned PAD_W      = 66;

    localparam logic [4:0] LAST_STEP = 5'(N_STEPS - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } div5_state_e;

endpackage

// File: rtl/div5_digit.sv
// One radix-8 long-division step by 5: v = 8*rem + digit, qd = v/5, rn = v%5.
module div5_digit
    import div5_pkg::*;
(
    input  logic [2:0] rem,
    input  logic [2:0] digit,
    output logic [2:0] qd,
    output logic [2:0] rn
);

    logic [5:0] v;

    // rem > 4 never occurs, so truncating the quotient to 3 bits is safe
    always_comb begin
        v  = {rem, digit};
        qd = 3'(v / 6'(DIVISOR));
        rn = 3'(v % 6'(DIVISOR));
    end

endmodule

// File: rtl/div5_serial_64.sv
// Serial unsigned 64-bit divide-by-5, one radix-8 digit per cycle, 22-cycle latency.
// Optional DIV5_SELFCHECK_EN adds a 5*q+r reconstruction check driving out_err.
module div5_serial_64
    import div5_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_q,
    output logic [2:0]   out_r,
    output logic         out_err
);

    div5_state_e      state_q, state_d;
    logic [PAD_W-1:0] opnd_q, opnd_d;
    logic [PAD_W-1:0] quo_q, quo_d;
    logic [2:0]       rem_q, rem_d;
    logic [4:0]       step_q, step_d;

    logic [2:0] digit, qd, rn;
    logic       is_done;
    logic       accept;

    assign digit   = opnd_q[PAD_W-1 -: RADIX_BITS];
    assign is_done = (state_q == StDone);
    assign accept  = (state_q == StIdle) && in_valid;

    div5_digit u_digit (
        .rem   (rem_q),
        .digit (digit),
        .qd    (qd),
        .rn    (rn)
    );

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        step_d  = step_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StBusy;
                    opnd_d  = {{(PAD_W - W){1'b0}}, in_x};
                    quo_d   = '0;
                    rem_d   = 3'd0;
                    step_d  = 5'd0;
                end
            end
            StBusy: begin
                opnd_d = opnd_q << RADIX_BITS;
                quo_d  = {quo_q[PAD_W-RADIX_BITS-1:0], qd};
                rem_d  = rn;
                if (step_q == LAST_STEP) begin
                    state_d = StDone;
                end else begin
                    step_d = step_q + 5'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            opnd_q  <= '0;
            quo_q   <= '0;
            rem_q   <= 3'd0;
            step_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            step_q  <= step_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = is_done;
    assign out_q     = is_done ? quo_q[W-1:0] : '0;
    assign out_r     = is_done ? rem_q : 3'd0;

    // Top quotient bits are structurally zero; only the self-check looks at them
    logic unused_quo_msb;
    assign unused_quo_msb = |quo_q[PAD_W-1:W];

`ifdef DIV5_SELFCHECK_EN
    localparam int unsigned RW = PAD_W + 2;

    logic [W-1:0]  x_q, x_d;
    logic [RW-1:0] recon;

    always_comb begin
        x_d = accept ? in_x : x_q;
        recon = {quo_q, 2'b00} + {2'b00, quo_q} + {{(RW - 3){1'b0}}, rem_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
        end else begin
            x_q <= x_d;
        end
    end

    assign out_err = is_done && ((recon != {{(RW - W){1'b0}}, x_q}) || (rem_q > 3'd4));
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign out_err       = 1'b0;
`endif

endmodule

// File: tb/tb_div5_serial_64.sv
// Self-checking bench for div5_serial_64: directed vectors, backpressure, reset abort, random.
module tb_div5_serial_64;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_x;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_q;
    logic [2:0]  out_r;
    logic        out_err;

    int n_cmp = 0;
    int n_bad = 0;

    div5_serial_64 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer x, wait for the result, hold out_ready low for 'hold' cycles, then consume.
    task automatic do_op(input logic [63:0] x, input logic [63:0] exp_q,
                         input logic [2:0] exp_r, input int hold);
        int lat;
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_x     = x;
        tick();
        in_valid = 1'b0;
        in_x     = $urandom;
        chk("busy_out_valid", 64'(out_valid), 64'd0);
        chk("busy_out_q_zero", out_q, 64'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            if (!out_valid) lat++;
        end
        chk("latency", 64'(lat), 64'd22);
        chk("out_q", out_q, exp_q);
        chk("out_r", 64'(out_r), 64'(exp_r));
        chk("out_err", 64'(out_err), 64'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_x     = ~x;
            tick();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_q", out_q, exp_q);
            chk("hold_r", 64'(out_r), 64'(exp_r));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_q_zero", out_q, 64'd0);
    endtask

    initial begin
        logic [63:0] x;
        int          saw_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_q", out_q, 64'd0);
        chk("rst_out_r", 64'(out_r), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);

        do_op(64'd0, 64'd0, 3'd0, 0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h3333_3333_3333_3333, 3'd0, 0);
        do_op(64'h8000_0000_0000_0000, 64'h1999_9999_9999_9999, 3'd3, 1);
        do_op(64'd7, 64'd1, 3'd2, 0);
        do_op(64'hFFFF_FFFF_FFFF_FFFE, 64'h3333_3333_3333_3332, 3'd4, 0);
        do_op(64'd4, 64'd0, 3'd4, 0);
        do_op(64'd5, 64'd1, 3'd0, 0);

        // Backpressure with a competing in_valid held during DONE
        do_op(64'd123_456_789, 64'd24_691_357, 3'd4, 10);

        // Reset at step 10 abandons the operation
        in_valid = 1'b1;
        in_x     = 64'h0123_4567_89AB_CDEF;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midbusy_rst_in_ready", 64'(in_ready), 64'd1);
        saw_valid = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) saw_valid++;
        end
        chk("midbusy_rst_no_valid", 64'(saw_valid), 64'd0);
        do_op(64'd24, 64'd4, 3'd4, 0);

        // Reset while in DONE drops the pending result
        in_valid = 1'b1;
        in_x     = 64'd99;
        tick();
        in_valid = 1'b0;
        repeat (22) tick();
        chk("done_before_rst", 64'(out_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("done_rst_valid", 64'(out_valid), 64'd0);
        chk("done_rst_q", out_q, 64'd0);
        chk("done_rst_in_ready", 64'(in_ready), 64'd1);

        // Random operands against plain 64-bit arithmetic
        for (int n = 0; n < 150; n++) begin
            x = {32'($urandom), 32'($urandom)};
            if (n % 10 == 0) x = x >> $urandom_range(63, 1);
            do_op(x, x / 64'd5, 3'(x % 64'd5), int'($urandom_range(3, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
